// File: rtl/charge_controller.sv
// charge_controller: coin/credit FSM for the charger. Collects credit under a Timer
// entry window, converts it to charge seconds and counts them down at 1 Hz.
`default_nettype none

module charge_controller #(
   parameter int CLK_HZ       = 1000,
   parameter int SEC_PER_UNIT = 60,
   parameter int MAX_CREDIT   = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  coin,
   input  logic        confirm,
   input  logic        cancel,
   input  logic        timer_timing,
   output logic        timer_start,
   output logic [7:0]  credit,
   output logic [15:0] remain,
   output logic        charging,
   output logic        coin_reject,
   output logic        refund,
   output logic [7:0]  refund_amt
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] c_PRESC_LAST  = PW'(CLK_HZ - 1);
   localparam logic [8:0]    c_MAX_CREDIT  = 9'(MAX_CREDIT);
   localparam logic [17:0]   c_REMAIN_CAP  = 18'(MAX_CREDIT * SEC_PER_UNIT);
   localparam logic [15:0]   c_REMAIN_CAP16 = 16'(MAX_CREDIT * SEC_PER_UNIT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ENTRY  = 2'd1,
      S_CHARGE = 2'd2
   } state_t;

   state_t        r_state;
   logic [7:0]    r_credit;
   logic [15:0]   r_remain;
   logic          r_charging;
   logic          r_timer_start;
   logic          r_coin_reject;
   logic          r_refund;
   logic [7:0]    r_refund_amt;
   logic [PW-1:0] r_presc;
   logic          r_timing_d;

   logic          w_coin_any;
   logic [2:0]    w_coin_val;
   logic [8:0]    w_credit_sum;
   logic          w_credit_ok;
   logic          w_timeout;
   logic          w_tick;
   logic [15:0]   w_remain_dec;
   logic [16:0]   w_coin_secs;
   logic [17:0]   w_remain_sum;
   logic          w_remain_sat;
   logic [15:0]   w_remain_next;
   logic [15:0]   w_charge_time;

   assign w_coin_any   = |coin;
   assign w_coin_val   = {2'b00, coin[0]} + (coin[1] ? 3'd5 : 3'd0);
   assign w_credit_sum = {1'b0, r_credit} + {6'b0, w_coin_val};
   assign w_credit_ok  = (w_credit_sum <= c_MAX_CREDIT);

   // A fall seen while the restart gap is on the wire is the Timer being re-armed.
   assign w_timeout    = r_timing_d & ~timer_timing & r_timer_start;

   assign w_tick        = (r_presc == c_PRESC_LAST);
   assign w_remain_dec  = (w_tick && (r_remain != 16'd0)) ? (r_remain - 16'd1) : r_remain;
   assign w_coin_secs   = 17'(w_coin_val) * 17'(SEC_PER_UNIT);
   assign w_remain_sum  = 18'(w_remain_dec) + 18'(w_coin_secs);
   assign w_remain_sat  = (w_remain_sum > c_REMAIN_CAP);
   assign w_remain_next = w_remain_sat ? c_REMAIN_CAP16 : w_remain_sum[15:0];
   assign w_charge_time = 16'(r_credit) * 16'(SEC_PER_UNIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_credit      <= 8'd0;
         r_remain      <= 16'd0;
         r_charging    <= 1'b0;
         r_timer_start <= 1'b0;
         r_coin_reject <= 1'b0;
         r_refund      <= 1'b0;
         r_refund_amt  <= 8'd0;
         r_presc       <= '0;
         r_timing_d    <= 1'b0;
      end else begin
         r_timing_d    <= timer_timing;
         r_coin_reject <= 1'b0;
         r_refund      <= 1'b0;
         r_refund_amt  <= 8'd0;

         case (r_state)
            S_IDLE: begin
               if (w_coin_any) begin
                  if ({6'b0, w_coin_val} <= c_MAX_CREDIT) begin
                     r_state       <= S_ENTRY;
                     r_credit      <= {5'b0, w_coin_val};
                     r_timer_start <= 1'b1;
                  end else begin
                     r_coin_reject <= 1'b1;
                  end
               end
            end

            S_ENTRY: begin
               if (cancel || (!confirm && w_timeout)) begin
                  r_state       <= S_IDLE;
                  r_refund      <= 1'b1;
                  r_refund_amt  <= r_credit;
                  r_credit      <= 8'd0;
                  r_timer_start <= 1'b0;
               end else if (confirm) begin
                  r_state       <= S_CHARGE;
                  r_remain      <= w_charge_time;
                  r_credit      <= 8'd0;
                  r_charging    <= 1'b1;
                  r_timer_start <= 1'b0;
                  r_presc       <= '0;
               end else begin
                  r_timer_start <= 1'b1;
                  if (w_coin_any) begin
                     if (w_credit_ok) begin
                        r_credit      <= w_credit_sum[7:0];
                        r_timer_start <= 1'b0;
                     end else begin
                        r_coin_reject <= 1'b1;
                     end
                  end
               end
            end

            S_CHARGE: begin
               if (cancel) begin
                  r_state    <= S_IDLE;
                  r_remain   <= 16'd0;
                  r_charging <= 1'b0;
                  r_presc    <= '0;
               end else begin
                  r_presc       <= w_tick ? '0 : (r_presc + 1'b1);
                  r_remain      <= w_remain_next;
                  r_coin_reject <= w_coin_any & w_remain_sat;
                  if (w_remain_next == 16'd0) begin
                     r_state    <= S_IDLE;
                     r_charging <= 1'b0;
                     r_presc    <= '0;
                  end
               end
            end

            default: begin
               r_state       <= S_IDLE;
               r_charging    <= 1'b0;
               r_timer_start <= 1'b0;
            end
         endcase
      end
   end

   assign timer_start = r_timer_start;
   assign credit      = r_credit;
   assign remain      = r_remain;
   assign charging    = r_charging;
   assign coin_reject = r_coin_reject;
   assign refund      = r_refund;
   assign refund_amt  = r_refund_amt;

endmodule

`default_nettype wire

// File: tb/tb_charge_controller.sv
// tb_charge_controller: directed checks of charge_controller against a simple Timer model.
`default_nettype none

module tb_charge_controller;

   localparam int WIN = 50;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  coin;
   logic        confirm;
   logic        cancel;
   logic        timer_timing;
   logic        timer_start;
   logic [7:0]  credit;
   logic [15:0] remain;
   logic        charging;
   logic        coin_reject;
   logic        refund;
   logic [7:0]  refund_amt;

   int n_cmp = 0;
   int n_err = 0;

   charge_controller #(
      .CLK_HZ      (10),
      .SEC_PER_UNIT(3),
      .MAX_CREDIT  (20)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .coin        (coin),
      .confirm     (confirm),
      .cancel      (cancel),
      .timer_timing(timer_timing),
      .timer_start (timer_start),
      .credit      (credit),
      .remain      (remain),
      .charging    (charging),
      .coin_reject (coin_reject),
      .refund      (refund),
      .refund_amt  (refund_amt)
   );

   always #5 clk = ~clk;

   // Timer: timing is high for WIN cycles after start rises, drops as soon as start drops.
   logic [7:0] tm_cnt;
   always @(posedge clk or posedge reset) begin
      if (reset)             tm_cnt <= 8'd0;
      else if (!timer_start) tm_cnt <= 8'd0;
      else if (tm_cnt < WIN) tm_cnt <= tm_cnt + 8'd1;
   end
   assign timer_timing = timer_start && (tm_cnt < WIN);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic [1:0] c, input logic cf, input logic cn);
      coin = c; confirm = cf; cancel = cn;
      @(posedge clk); #1;
      coin = 2'b00; confirm = 1'b0; cancel = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      bit found;
      reset = 1'b1; coin = 2'b00; confirm = 1'b0; cancel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ts", 32'(timer_start), 0);
      chk("rst_charging", 32'(charging), 0);
      reset = 1'b0;

      // 1. reset mid-charge
      cyc(2'b01, 0, 0); cyc(2'b01, 0, 0); cyc(2'b01, 0, 0);
      chk("t1_credit3", 32'(credit), 3);
      cyc(2'b00, 1, 0);
      chk("t1_remain9", 32'(remain), 9);
      idle(20);
      chk("t1_remain7", 32'(remain), 7);
      chk("t1_charging", 32'(charging), 1);
      reset = 1'b1;
      #1;
      chk("t1_async_remain", 32'(remain), 0);
      chk("t1_async_charging", 32'(charging), 0);
      chk("t1_async_credit", 32'(credit), 0);
      chk("t1_async_ts", 32'(timer_start), 0);
      chk("t1_async_misc", {29'd0, coin_reject, refund, |refund_amt}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      cyc(2'b01, 0, 0);
      chk("t1_credit1", 32'(credit), 1);
      chk("t1_ts1", 32'(timer_start), 1);
      cyc(2'b00, 0, 1);
      chk("t1_cancel_refund", 32'(refund), 1);
      chk("t1_cancel_amt", 32'(refund_amt), 1);

      // 2. accumulate 1, 6, 12 then charge 36 s
      cyc(2'b01, 0, 0);
      chk("t2_credit1", 32'(credit), 1);
      chk("t2_ts_entry", 32'(timer_start), 1);
      cyc(2'b10, 0, 0);
      chk("t2_credit6", 32'(credit), 6);
      chk("t2_gap1", 32'(timer_start), 0);
      idle(1);
      chk("t2_gap1_end", 32'(timer_start), 1);
      cyc(2'b11, 0, 0);
      chk("t2_credit12", 32'(credit), 12);
      chk("t2_gap2", 32'(timer_start), 0);
      idle(1);
      chk("t2_gap2_end", 32'(timer_start), 1);
      cyc(2'b00, 1, 0);
      chk("t2_remain36", 32'(remain), 36);
      chk("t2_charging", 32'(charging), 1);
      chk("t2_credit0", 32'(credit), 0);
      chk("t2_ts0", 32'(timer_start), 0);
      idle(9);
      chk("t2_remain36_c9", 32'(remain), 36);
      idle(1);
      chk("t2_remain35_c10", 32'(remain), 35);
      idle(349);
      chk("t2_remain1_c359", 32'(remain), 1);
      chk("t2_charging_c359", 32'(charging), 1);
      idle(1);
      chk("t2_remain0_c360", 32'(remain), 0);
      chk("t2_charging_c360", 32'(charging), 0);

      // 3. saturation reject at 18
      cyc(2'b11, 0, 0); cyc(2'b11, 0, 0); cyc(2'b11, 0, 0);
      chk("t3_credit18", 32'(credit), 18);
      idle(1);
      cyc(2'b10, 0, 0);
      chk("t3_reject", 32'(coin_reject), 1);
      chk("t3_credit_held", 32'(credit), 18);
      chk("t3_no_gap", 32'(timer_start), 1);
      cyc(2'b01, 0, 0);
      chk("t3_credit19", 32'(credit), 19);
      chk("t3_reject_clear", 32'(coin_reject), 0);
      cyc(2'b00, 0, 1);
      chk("t3_refund_amt", 32'(refund_amt), 19);

      // 4. timeout refund
      cyc(2'b01, 0, 0); cyc(2'b01, 0, 0); cyc(2'b01, 0, 0); cyc(2'b01, 0, 0);
      chk("t4_credit4", 32'(credit), 4);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (refund) begin
            found = 1'b1;
            break;
         end
      end
      chk("t4_refund_seen", 32'(found), 1);
      chk("t4_refund_amt", 32'(refund_amt), 4);
      chk("t4_ts0", 32'(timer_start), 0);
      chk("t4_credit0", 32'(credit), 0);
      idle(1);
      chk("t4_refund_pulse", 32'(refund), 0);

      // 5. confirm + cancel together
      cyc(2'b01, 0, 0); cyc(2'b01, 0, 0); cyc(2'b01, 0, 0);
      cyc(2'b00, 1, 1);
      chk("t5_refund", 32'(refund), 1);
      chk("t5_refund_amt", 32'(refund_amt), 3);
      chk("t5_charging", 32'(charging), 0);
      chk("t5_remain", 32'(remain), 0);

      // 6. remain cap and cancel during charge
      cyc(2'b11, 0, 0); cyc(2'b11, 0, 0); cyc(2'b11, 0, 0);
      cyc(2'b01, 0, 0); cyc(2'b01, 0, 0);
      chk("t6_credit20", 32'(credit), 20);
      cyc(2'b00, 1, 0);
      chk("t6_remain60", 32'(remain), 60);
      idle(20);
      chk("t6_remain58", 32'(remain), 58);
      cyc(2'b01, 0, 0);
      chk("t6_remain_cap", 32'(remain), 60);
      chk("t6_reject", 32'(coin_reject), 1);
      cyc(2'b00, 0, 1);
      chk("t6_cancel_remain", 32'(remain), 0);
      chk("t6_cancel_charging", 32'(charging), 0);
      chk("t6_no_refund", 32'(refund), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
